// File: rtl/serial_add_pkg.sv
// Shared types and defaults for the bit-serial adder controller.
package serial_add_pkg;

    localparam int unsigned WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/full_adder.sv
// One-bit full-adder cell, time-shared by the serial controller.
module full_adder (
    input  logic a_in,
    input  logic b_in,
    input  logic c_in,
    output logic sum,
    output logic carry
);

    assign sum   = a_in ^ b_in ^ c_in;
    assign carry = (a_in & b_in) | (c_in & (a_in ^ b_in));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder sequencer: one full-adder cell, LSB first, registered carry.
// Optional subtract mode (sub_in port) is enabled by defining SERIAL_ADD_SUB_EN.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_in,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             c_in,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub_in,
`endif
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
    output logic             carry_out
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam int unsigned ACC_W = WIDTH - 1;

    state_t             state;
    state_t             state_nxt;
    logic [WIDTH-1:0]   a_sr;
    logic [WIDTH-1:0]   b_sr;
    logic [ACC_W-1:0]   acc_sr;
    logic               carry;
    logic [CNT_W-1:0]   cnt;
    logic               last;
    logic               cell_sum;
    logic               cell_carry;
    logic [WIDTH-1:0]   b_load;
    logic               c_load;

    full_adder u_cell (
        .a_in  (a_sr[0]),
        .b_in  (b_sr[0]),
        .c_in  (carry),
        .sum   (cell_sum),
        .carry (cell_carry)
    );

    assign last = (cnt == CNT_W'(WIDTH - 1));

    // Operand B / carry seen at capture; subtract loads ~B with a forced carry of 1.
    always_comb begin
        b_load = b_in;
        c_load = c_in;
`ifdef SERIAL_ADD_SUB_EN
        if (sub_in) begin
            b_load = ~b_in;
            c_load = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_in) state_nxt = SHIFT;
            SHIFT:   if (last)     state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ready = 1'b0;
        busy  = 1'b0;
        done  = 1'b0;
        case (state)
            IDLE:    ready = 1'b1;
            SHIFT:   busy  = 1'b1;
            DONE:    done  = 1'b1;
            default: ready = 1'b0;
        endcase
    end

    // Datapath: capture on accepted start, then one bit pair per cycle through the cell.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr      <= '0;
            b_sr      <= '0;
            acc_sr    <= '0;
            carry     <= 1'b0;
            cnt       <= '0;
            sum_out   <= '0;
            carry_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_in) begin
                        a_sr  <= a_in;
                        b_sr  <= b_load;
                        carry <= c_load;
                        cnt   <= '0;
                    end
                end
                SHIFT: begin
                    acc_sr <= (acc_sr >> 1) | (ACC_W'(cell_sum) << (ACC_W - 1));
                    carry  <= cell_carry;
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    cnt    <= cnt + CNT_W'(1);
                    if (last) begin
                        sum_out   <= {cell_sum, acc_sr};
                        carry_out <= cell_carry;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl: expected results queued at start, checked on done.
// Subtract cases run only when SERIAL_ADD_SUB_EN is defined.
module tb_serial_add_ctrl;
    import serial_add_pkg::*;

    localparam int unsigned W = WIDTH_DEF;

    logic         clk = 1'b0;
    logic         rst;
    logic         start_in;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         c_in;
`ifdef SERIAL_ADD_SUB_EN
    logic         sub_in;
`endif
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] sum_out;
    logic         carry_out;

    int           n_checks   = 0;
    int           n_fail     = 0;
    int           n_done     = 0;
    int           n_exp_done = 0;
    logic [W:0]   sb_q[$];
    logic [W:0]   sb_exp;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start_in  (start_in),
        .a_in      (a_in),
        .b_in      (b_in),
        .c_in      (c_in),
`ifdef SERIAL_ADD_SUB_EN
        .sub_in    (sub_in),
`endif
        .ready     (ready),
        .busy      (busy),
        .done      (done),
        .sum_out   (sum_out),
        .carry_out (carry_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard: every done pulse must match the oldest queued result.
    always @(negedge clk) begin
        if (done) begin
            n_done++;
            if (sb_q.size() == 0) begin
                check("unexpected_done", 32'(done), 32'd0);
            end else begin
                sb_exp = sb_q.pop_front();
                check("sum_out", 32'(sum_out), 32'(sb_exp[W-1:0]));
                check("carry_out", 32'(carry_out), 32'(sb_exp[W]));
            end
        end
    end

    task automatic wait_ready();
        int i = 0;
        while (!ready && i < 64) begin
            @(negedge clk);
            i++;
        end
        check("ready_wait", 32'(ready), 32'd1);
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic c, input logic sub, input logic noise);
        logic [W-1:0] nb;
        logic [W:0]   exp;
        nb = ~b;
        if (sub) exp = (W+1)'(a) + (W+1)'(nb) + (W+1)'(1);
        else     exp = (W+1)'(a) + (W+1)'(b) + (W+1)'(c);
        wait_ready();
        start_in = 1'b1;
        a_in     = a;
        b_in     = b;
        c_in     = c;
`ifdef SERIAL_ADD_SUB_EN
        sub_in   = sub;
`endif
        sb_q.push_back(exp);
        n_exp_done++;
        @(negedge clk);
        start_in = 1'b0;
        for (int i = 1; i <= int'(W); i++) begin
            check("busy_shift", 32'(busy), 32'd1);
            check("ready_shift", 32'(ready), 32'd0);
            check("done_shift", 32'(done), 32'd0);
            if (noise) begin
                a_in     = W'($urandom);
                b_in     = W'($urandom);
                c_in     = 1'($urandom_range(0, 1));
                start_in = 1'($urandom_range(0, 1));
`ifdef SERIAL_ADD_SUB_EN
                sub_in   = 1'($urandom_range(0, 1));
`endif
            end
            @(negedge clk);
        end
        check("done_pulse", 32'(done), 32'd1);
        check("busy_done", 32'(busy), 32'd0);
        check("ready_done", 32'(ready), 32'd0);
        start_in = 1'b0;
        @(negedge clk);
        check("ready_back", 32'(ready), 32'd1);
        check("done_single", 32'(done), 32'd0);
    endtask

    initial begin
        rst      = 1'b1;
        start_in = 1'b0;
        a_in     = '0;
        b_in     = '0;
        c_in     = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
        sub_in   = 1'b0;
`endif
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_ready", 32'(ready), 32'd1);
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_done", 32'(done), 32'd0);
            check("idle_sum", 32'(sum_out), 32'd0);
            check("idle_carry", 32'(carry_out), 32'd0);
        end

        run_op(8'h3C, 8'h45, 1'b0, 1'b0, 1'b0);
        run_op(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
        run_op(8'h7F, 8'h00, 1'b1, 1'b0, 1'b0);
        run_op(8'hA5, 8'h5A, 1'b1, 1'b0, 1'b1);
        run_op(8'h12, 8'h34, 1'b0, 1'b0, 1'b1);

        // Abort in the third SHIFT cycle: no done, result registers cleared.
        wait_ready();
        start_in = 1'b1;
        a_in     = 8'hAA;
        b_in     = 8'h56;
        c_in     = 1'b0;
        @(negedge clk);
        start_in = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_ready", 32'(ready), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_sum", 32'(sum_out), 32'd0);
        check("abort_carry", 32'(carry_out), 32'd0);

        // Reset and start together: reset wins.
        rst      = 1'b1;
        start_in = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        start_in = 1'b0;
        check("rst_start_ready", 32'(ready), 32'd1);
        check("rst_start_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("rst_start_idle", 32'(busy), 32'd0);

        run_op(8'h10, 8'h20, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)));
        end

`ifdef SERIAL_ADD_SUB_EN
        run_op(8'h10, 8'h01, 1'b0, 1'b1, 1'b0);
        run_op(8'h01, 8'h02, 1'b1, 1'b1, 1'b0);
        run_op(8'h55, 8'h55, 1'b0, 1'b1, 1'b1);
        run_op(8'h3C, 8'h45, 1'b0, 1'b0, 1'b0);
`endif

        repeat (5) @(negedge clk);
        check("sb_empty", 32'(sb_q.size()), 32'd0);
        check("done_count", 32'(n_done), 32'(n_exp_done));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
